// File: rtl/simd_result_buffer.sv
// simd_result_buffer
// Collects per-lane SIMD results into tagged result sets and queues up to
// DEPTH closed sets for the stack upstream interface. Each set is filled
// lane by lane (overwrite or accumulate) while open. It is committed on
// close and presented in order until sui signals completion. Protocol
// misuse raises sticky error flags: overflow, orphan result and
// unexpected complete.
module simd_result_buffer #(
  parameter int NUM_LANES  = 32,
  parameter int LANE_WIDTH = 32,
  parameter int TAG_WIDTH  = 8,
  parameter int DEPTH      = 2
) (
  input  logic                            clk,
  input  logic                            reset_poweron,
  input  logic                            cfg_accumulate,
  input  logic [TAG_WIDTH-1:0]            cntl__simd__tag,
  input  logic                            cntl__simd__set_start,
  input  logic                            cntl__simd__set_close,
  output logic                            simd__cntl__ready,
  input  logic [NUM_LANES-1:0]            lane_result_valid,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] lane_result,
  output logic                            simd__sui__set_valid,
  output logic [TAG_WIDTH-1:0]            simd__sui__tag,
  output logic [NUM_LANES*LANE_WIDTH-1:0] simd__sui__regs,
  output logic [NUM_LANES-1:0]            simd__sui__regs_valid,
  input  logic                            sui__simd__regs_complete,
  output logic [2:0]                      simd__err
);

  localparam int DATA_W = NUM_LANES * LANE_WIDTH;
  // A single-entry buffer still needs a 1-bit pointer to keep the array
  // index well formed; the increment below wraps it back to zero.
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  // ---------------------------------------------------------------------
  // Storage and control state
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0]    data_reg [DEPTH];
  logic [NUM_LANES-1:0] mask_reg [DEPTH];
  logic [TAG_WIDTH-1:0] tag_reg  [DEPTH];

  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [PTR_W-1:0]     rd_ptr_reg;
  logic [CNT_W-1:0]     count_reg;
  logic                 open_reg;
  logic [2:0]           err_reg;

  // Modulo-DEPTH pointer increment (DEPTH need not fill the pointer range)
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // ---------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------
  logic [CNT_W:0]       occupancy;
  logic                 ready;
  logic                 close_fire;
  logic                 start_ok;
  logic                 start_drop;
  logic                 restart;
  logic                 head_valid;
  logic                 pop;
  logic                 bad_complete;
  logic                 orphan;
  logic [PTR_W-1:0]     new_ptr;
  logic [CNT_W-1:0]     count_next;

  // Occupancy counts committed sets plus the one being filled. While a set
  // is open this already equals count+1, so the same ready term also
  // decides whether a start issued together with a close can be honoured.
  always_comb begin
    occupancy    = {1'b0, count_reg} + (CNT_W + 1)'(open_reg);
    ready        = (occupancy < DEPTH_C);
    close_fire   = cntl__simd__set_close & open_reg;
    start_ok     = cntl__simd__set_start & ready;
    start_drop   = cntl__simd__set_start & ~ready;
    // A start on an already open set without a close re-opens that entry.
    restart      = start_ok & open_reg & ~close_fire;
    head_valid   = (count_reg != '0);
    pop          = sui__simd__regs_complete & head_valid;
    bad_complete = sui__simd__regs_complete & ~head_valid;
    orphan       = (|lane_result_valid) & ~open_reg;
    new_ptr      = close_fire ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
    count_next   = count_reg + CNT_W'(close_fire) - CNT_W'(pop);
  end

  // ---------------------------------------------------------------------
  // Fill-entry lane update
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0]    fill_data_old;
  logic [NUM_LANES-1:0] fill_mask_old;
  logic [NUM_LANES-1:0] fill_mask_next;
  wire  [DATA_W-1:0]    fill_data_next;

  // Current contents of the entry being filled, plus its updated mask
  always_comb begin
    fill_data_old  = data_reg[wr_ptr_reg];
    fill_mask_old  = mask_reg[wr_ptr_reg];
    fill_mask_next = restart ? lane_result_valid
                             : (fill_mask_old | lane_result_valid);
  end

  // Per lane: overwrite, or add into a lane already written in this set.
  // On a restart the old contents are treated as cleared.
  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      wire [LANE_WIDTH-1:0] old_lane = fill_data_old[gi*LANE_WIDTH +: LANE_WIDTH];
      wire [LANE_WIDTH-1:0] in_lane  = lane_result[gi*LANE_WIDTH +: LANE_WIDTH];
      wire                  acc_lane = cfg_accumulate & fill_mask_old[gi] & ~restart;
      wire [LANE_WIDTH-1:0] wr_lane  = acc_lane ? (old_lane + in_lane) : in_lane;
      assign fill_data_next[gi*LANE_WIDTH +: LANE_WIDTH] =
          lane_result_valid[gi] ? wr_lane : (restart ? '0 : old_lane);
    end
  endgenerate

  // ---------------------------------------------------------------------
  // State update
  // ---------------------------------------------------------------------
  // Entry writes, pointer/count bookkeeping and sticky errors. The open
  // entry is never the head while sets are queued, so committed data is
  // never disturbed. On close+start the new set is opened in the entry
  // after the one being committed.
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      for (int e = 0; e < DEPTH; e++) begin
        data_reg[e] <= '0;
        mask_reg[e] <= '0;
        tag_reg[e]  <= '0;
      end
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      open_reg   <= 1'b0;
      err_reg    <= '0;
    end else begin
      if (open_reg) begin
        data_reg[wr_ptr_reg] <= fill_data_next;
        mask_reg[wr_ptr_reg] <= fill_mask_next;
      end
      if (start_ok) begin
        tag_reg[new_ptr] <= cntl__simd__tag;
        if (!restart) begin
          data_reg[new_ptr] <= '0;
          mask_reg[new_ptr] <= '0;
        end
      end
      if (close_fire) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      count_reg <= count_next;
      if (start_ok) begin
        open_reg <= 1'b1;
      end else if (close_fire) begin
        open_reg <= 1'b0;
      end
      err_reg <= err_reg | {bad_complete, orphan, start_drop};
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  // Present the head entry only while a set is queued; otherwise drive zeros
  always_comb begin
    simd__cntl__ready     = ready;
    simd__sui__set_valid  = head_valid;
    simd__sui__tag        = head_valid ? tag_reg[rd_ptr_reg]  : '0;
    simd__sui__regs       = head_valid ? data_reg[rd_ptr_reg] : '0;
    simd__sui__regs_valid = head_valid ? mask_reg[rd_ptr_reg] : '0;
    simd__err             = err_reg;
  end

endmodule

// File: tb/tb_simd_result_buffer.sv
// tb_simd_result_buffer
// Scoreboard bench: a bench-side model of the open fill set is updated as
// stimulus is driven. The model pushes an expected set on every accepted
// close and pops one on every accepted complete. The queue head is compared
// against the presented sui outputs after each clock edge.
module tb_simd_result_buffer;

  localparam int NL = 32;
  localparam int LW = 32;
  localparam int TW = 8;
  localparam int D  = 2;

  logic              clk = 1'b0;
  logic              reset_poweron = 1'b0;
  logic              cfg_accumulate = 1'b0;
  logic [TW-1:0]     tag_in = '0;
  logic              set_start = 1'b0;
  logic              set_close = 1'b0;
  logic              ready;
  logic [NL-1:0]     lane_valid = '0;
  logic [NL*LW-1:0]  lane_data = '0;
  logic              set_valid;
  logic [TW-1:0]     sui_tag;
  logic [NL*LW-1:0]  sui_regs;
  logic [NL-1:0]     sui_regs_valid;
  logic              complete = 1'b0;
  logic [2:0]        err;

  simd_result_buffer #(
    .NUM_LANES(NL), .LANE_WIDTH(LW), .TAG_WIDTH(TW), .DEPTH(D)
  ) dut (
    .clk                      (clk),
    .reset_poweron            (reset_poweron),
    .cfg_accumulate           (cfg_accumulate),
    .cntl__simd__tag          (tag_in),
    .cntl__simd__set_start    (set_start),
    .cntl__simd__set_close    (set_close),
    .simd__cntl__ready        (ready),
    .lane_result_valid        (lane_valid),
    .lane_result              (lane_data),
    .simd__sui__set_valid     (set_valid),
    .simd__sui__tag           (sui_tag),
    .simd__sui__regs          (sui_regs),
    .simd__sui__regs_valid    (sui_regs_valid),
    .sui__simd__regs_complete (complete),
    .simd__err                (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0]    tag;
    logic [NL-1:0]    mask;
    logic [NL*LW-1:0] data;
  } set_t;

  set_t       exp_q[$];
  set_t       fill;
  bit         m_open;
  int         m_count;
  logic [2:0] m_err;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic bit model_ready();
    return (m_count + int'(m_open)) < D;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_open  = 1'b0;
    m_count = 0;
    m_err   = '0;
    fill    = '{tag: '0, mask: '0, data: '0};
  endtask

  // Compare presented head, ready and error flags against the scoreboard
  task automatic check_outputs();
    set_t h;
    bit   hv;
    hv = (exp_q.size() != 0);
    if (hv) h = exp_q[0];
    else    h = '{tag: '0, mask: '0, data: '0};
    check("set_valid", 64'(set_valid), 64'(hv));
    check("tag", 64'(sui_tag), 64'(h.tag));
    check("regs_valid", 64'(sui_regs_valid), 64'(h.mask));
    for (int i = 0; i < NL; i++)
      check($sformatf("lane%0d", i), 64'(sui_regs[i*LW +: LW]), 64'(h.data[i*LW +: LW]));
    check("err", 64'(err), 64'(m_err));
    check("ready", 64'(ready), 64'(model_ready()));
  endtask

  // One clock of stimulus; the model follows the documented behaviour
  task automatic step(input bit st, input logic [TW-1:0] tg, input bit cl,
                      input logic [NL-1:0] v, input logic [NL*LW-1:0] d,
                      input bit acc, input bit cmp);
    bit rdy;
    rdy = model_ready();
    set_start      = st;
    tag_in         = tg;
    set_close      = cl;
    lane_valid     = v;
    lane_data      = d;
    cfg_accumulate = acc;
    complete       = cmp;
    check("ready_pre", 64'(ready), 64'(rdy));
    // complete: pop using the pre-edge count
    if (cmp) begin
      if (m_count > 0) begin
        $display("pop  tag=%02h mask=%08h", exp_q[0].tag, exp_q[0].mask);
        void'(exp_q.pop_front());
        m_count--;
      end else begin
        m_err[2] = 1'b1;
      end
    end
    // lane writes
    if (m_open) begin
      for (int i = 0; i < NL; i++) begin
        if (v[i]) begin
          if (acc && fill.mask[i])
            fill.data[i*LW +: LW] = fill.data[i*LW +: LW] + d[i*LW +: LW];
          else
            fill.data[i*LW +: LW] = d[i*LW +: LW];
          fill.mask[i] = 1'b1;
        end
      end
    end else if (v != '0) begin
      m_err[1] = 1'b1;
    end
    // close commits the set including this cycle's writes
    if (cl && m_open) begin
      $display("push tag=%02h mask=%08h", fill.tag, fill.mask);
      exp_q.push_back(fill);
      m_count++;
      m_open = 1'b0;
    end
    // start opens a clean set when there was room before the edge
    if (st) begin
      if (rdy) begin
        m_open = 1'b1;
        fill   = '{tag: tg, mask: '0, data: '0};
      end else begin
        m_err[0] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    set_start  = 1'b0;
    set_close  = 1'b0;
    lane_valid = '0;
    lane_data  = '0;
    complete   = 1'b0;
    check_outputs();
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  function automatic logic [NL*LW-1:0] one_lane(input int lane, input logic [LW-1:0] val);
    logic [NL*LW-1:0] r;
    r = '0;
    r[lane*LW +: LW] = val;
    return r;
  endfunction

  task automatic check_reset_state();
    check("rst_set_valid", 64'(set_valid), 64'(0));
    check("rst_tag", 64'(sui_tag), 64'(0));
    check("rst_regs_nonzero", 64'(sui_regs != '0), 64'(0));
    check("rst_regs_valid", 64'(sui_regs_valid), 64'(0));
    check("rst_ready", 64'(ready), 64'(1));
    check("rst_err", 64'(err), 64'(0));
  endtask

  initial begin
    logic [NL*LW-1:0] rd;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    reset_poweron = 1'b1;
    @(negedge clk);

    // 1: reset mid-fill discards everything; a fresh set then works
    step(1'b1, 8'h33, 1'b0, '0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 32'h1, one_lane(0, 32'hABCD), 1'b0, 1'b0);
    step(1'b1, 8'h34, 1'b1, '0, '0, 1'b0, 1'b0);   // commit one, open another
    #2 reset_poweron = 1'b0;
    #1 check_reset_state();
    model_reset();
    @(negedge clk);
    reset_poweron = 1'b1;
    step(1'b1, 8'h44, 1'b0, '0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 32'h4, one_lane(2, 32'h77), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);

    // 2: overwrite
    step(1'b1, 8'h5A, 1'b0, '0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 32'h8, one_lane(3, 32'h11), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 32'h8, one_lane(3, 32'h22), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, '0, '0, 1'b0, 1'b0);
    check("ovw_tag", 64'(sui_tag), 64'(8'h5A));
    check("ovw_mask", 64'(sui_regs_valid), 64'(32'h8));
    check("ovw_lane3", 64'(sui_regs[3*LW +: LW]), 64'(32'h22));
    step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);

    // 3: accumulate with wrap
    step(1'b1, 8'h01, 1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 32'h1, one_lane(0, 32'hFFFF_FFFF), 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 32'h1, one_lane(0, 32'h2), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, '0, '0, 1'b1, 1'b0);
    check("acc_lane0", 64'(sui_regs[0 +: LW]), 64'(32'h1));
    step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    check("acc_empty", 64'(set_valid), 64'(0));

    // 4: full buffer, overflow start, drain
    step(1'b1, 8'hA1, 1'b0, '0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 32'h2, one_lane(1, 32'h5), 1'b0, 1'b0);
    step(1'b1, 8'hB2, 1'b0, '0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, '0, '0, 1'b0, 1'b0);          // empty set still committed
    check("full_ready", 64'(ready), 64'(0));
    step(1'b1, 8'hC3, 1'b0, '0, '0, 1'b0, 1'b0);
    check("full_err0", 64'(err[0]), 64'(1));
    step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    check("drain_tag", 64'(sui_tag), 64'(8'hB2));
    check("drain_ready", 64'(ready), 64'(1));
    step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);

    // 5: close+start with a lane write; commit and pop in one cycle
    step(1'b1, 8'h10, 1'b0, 32'h0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 32'h20, one_lane(5, 32'h7), 1'b0, 1'b0);
    step(1'b1, 8'h20, 1'b1, 32'h20, one_lane(5, 32'h9), 1'b0, 1'b0);
    check("sim_lane5", 64'(sui_regs[5*LW +: LW]), 64'(32'h9));
    step(1'b0, '0, 1'b0, 32'h2, one_lane(1, 32'h3), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, '0, '0, 1'b0, 1'b1);          // commit + pop together
    check("sim_mask2", 64'(sui_regs_valid), 64'(32'h2));
    step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);

    // 6: orphan write and unexpected complete leave the queue untouched
    step(1'b1, 8'h66, 1'b0, '0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 32'h1, one_lane(0, 32'h66), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 32'hF0, {NL{32'h1234_5678}}, 1'b0, 1'b0);
    check("orphan_err1", 64'(err[1]), 64'(1));
    step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    check("unexp_err2", 64'(err[2]), 64'(1));
    idle();

    // Random traffic (restart of an open set without close is not exercised)
    for (int n = 0; n < 400; n++) begin
      bit st, cl, cmp, acc;
      logic [NL-1:0] v;
      cl  = m_open && ($urandom_range(0, 3) == 0);
      st  = m_open ? (cl && $urandom_range(0, 1) == 1) : ($urandom_range(0, 2) == 0);
      cmp = $urandom_range(0, 3) == 0;
      acc = $urandom_range(0, 1) == 1;
      v   = NL'($urandom & $urandom & $urandom);
      for (int i = 0; i < NL; i++) rd[i*LW +: LW] = $urandom;
      step(st, TW'($urandom), cl, v, rd, acc, cmp);
    end
    repeat (4) step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
